// File: rtl/data_mem_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// data_mem_ctrl
// -----------------------------------------------------------------------------
// Multi-cycle data-memory stage that sits behind the ALU/register file and
// feeds the MemToReg mux. It accepts one load or store per request, holds the
// word-addressed data array internally, models a fixed access latency, and
// stalls the CPU (PC and RegWrite) until the access has completed.
// Misaligned and out-of-range byte addresses are rejected without touching
// the array.
//
// Parameters
//   ADDR_W  : word-index width; the array holds 2**ADDR_W 32-bit words
//   LATENCY : BUSY cycles per access, legal range 1..15
//
// Ports
//   clk_i       in   1  clock, rising edge
//   rst_i       in   1  asynchronous, active-low reset
//   req_i       in   1  access request (MemRead or MemWrite from Control)
//   we_i        in   1  1 = store, 0 = load; sampled with req_i
//   addr_i      in  32  byte address from the ALU result
//   wdata_i     in  32  store data from the RT register
//   be_i        in   4  byte enables for stores (only with DATA_MEM_BYTE_STROBE_EN)
//   rdata_o     out 32  load data; holds the last successful load value
//   stall_o     out  1  freeze PC and suppress RegWrite while high
//   done_o      out  1  one-cycle pulse: access complete
//   err_o       out  1  one-cycle pulse with done_o: access rejected
//   dbg_state_o out  2  current FSM state (IDLE=0, BUSY=1, DONE=2)
//
// Optional feature
//   DATA_MEM_BYTE_STROBE_EN : when defined, adds be_i and makes stores write
//   only the enabled bytes. When undefined, every store writes all 32 bits.
//
// Handshake: a request is accepted only in IDLE while req_i is high; from
// then on req_i and all data inputs are ignored until the FSM is back in
// IDLE. stall_o is high from the accepting cycle through the last BUSY
// cycle; done_o (and err_o for rejects) pulses for exactly one cycle in DONE.
// -----------------------------------------------------------------------------
module data_mem_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
`ifdef DATA_MEM_BYTE_STROBE_EN
  input  logic [3:0]  be_i,
`endif
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        done_o,
  output logic        err_o,
  output logic [1:0]  dbg_state_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Down-counter start value; the access happens on the edge where the
  // counter is already zero, so LATENCY-1 yields exactly LATENCY BUSY cycles.
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  // First byte address past the array, computed one bit wider than addr_i
  // so the comparison stays exact even for large ADDR_W.
  localparam logic [32:0] ADDR_LIMIT = 33'd4 << ADDR_W;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q,   cnt_d;
  logic              we_q,    we_d;
  // Only the word index of the latched address matters once the range and
  // alignment checks have passed, so that is all that is kept.
  logic [ADDR_W-1:0] idx_q,   idx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              done_q,  done_d;
  logic              err_q,   err_d;
`ifdef DATA_MEM_BYTE_STROBE_EN
  logic [3:0]        be_q,    be_d;
`endif

  // Data array: intentionally not reset.
  logic [31:0]       mem_q [DEPTH];

  // Array write strobe and merged write word.
  logic              mem_wr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rword;

  // Request classification.
  logic              addr_misaligned;
  logic              addr_out_of_range;
  logic              addr_bad;

  assign addr_misaligned   = (addr_i[1:0] != 2'b00);
  assign addr_out_of_range = ({1'b0, addr_i} >= ADDR_LIMIT);
  assign addr_bad          = addr_misaligned | addr_out_of_range;

  assign mem_rword = mem_q[idx_q];

  // ---------------------------------------------------------------------------
  // Store data merge
  // ---------------------------------------------------------------------------
`ifdef DATA_MEM_BYTE_STROBE_EN
  // Read-modify-write of the addressed word: disabled bytes keep the current
  // array contents, so be=0000 rewrites the word unchanged.
  always_comb begin
    mem_wdata = mem_rword;
    for (int b = 0; b < 4; b++) begin
      if (be_q[b]) begin
        mem_wdata[8*b +: 8] = wdata_q[8*b +: 8];
      end
    end
  end
`else
  assign mem_wdata = wdata_q;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    mem_wr  = 1'b0;
`ifdef DATA_MEM_BYTE_STROBE_EN
    be_d    = be_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          we_d    = we_i;
          idx_d   = addr_i[ADDR_W+1:2];
          wdata_d = wdata_i;
`ifdef DATA_MEM_BYTE_STROBE_EN
          be_d    = be_i;
`endif
          if (addr_bad) begin
            // Rejected: skip BUSY entirely, array is never touched.
            state_d = ST_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = ST_BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end

      ST_BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          if (we_q) begin
            mem_wr = 1'b1;
          end else begin
            rdata_d = mem_rword;
          end
        end
      end

      ST_DONE: begin
        // req_i is not looked at here; a held request is re-sampled in IDLE.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef DATA_MEM_BYTE_STROBE_EN
      be_q    <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef DATA_MEM_BYTE_STROBE_EN
      be_q    <= be_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Data array write port
  // ---------------------------------------------------------------------------
  // mem_wr is only raised from BUSY, and reset forces IDLE asynchronously, so
  // a reset during BUSY can never let the pending store reach the array.
  always_ff @(posedge clk_i) begin
    if (mem_wr) begin
      mem_q[idx_q] <= mem_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // stall_o covers the accepting IDLE cycle combinationally so the PC does
  // not advance on the same edge the request is taken.
  assign stall_o     = ((state_q == ST_IDLE) && req_i) || (state_q == ST_BUSY);
  assign rdata_o     = rdata_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Multi-cycle data-memory stage downstream of the CPU's ALU/register file; replaces the single-cycle data memory behind the MemToReg mux.
- Accepts one load or store per request, models a fixed access latency, and stalls the CPU (PC and register write) until the access completes.
- Holds the word-addressed data array internally.
- Flags misaligned and out-of-range accesses.

Parameters:
ADDR_W, 8, word-index width; array depth = 2**ADDR_W 32-bit words
LATENCY, 2, BUSY cycles per access; legal range 1..15

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous, active-low reset
req_i  input  1  access request (MemRead or MemWrite asserted by Control)
we_i  input  1  1 = store, 0 = load; sampled with req_i
addr_i  input  32  byte address from the ALU result
wdata_i  input  32  store data from the RT register
rdata_o  output  32  load data to the MemToReg mux
stall_o  output  1  freeze PC and suppress RegWrite while high
done_o  output  1  one-cycle pulse: access complete, rdata_o valid for loads
err_o  output  1  one-cycle pulse with done_o: access rejected

Behaviour:
- Reset state (asynchronous on rst_i=0):
  - state=IDLE, cnt=0, rdata_o=0, done_o=0, err_o=0, stall_o=0.
  - Array contents are not reset.
- State machine IDLE, BUSY, DONE. The state, cnt, the latched we/addr/wdata, rdata_o, done_o and err_o are registers.
- stall_o is combinational: (state==IDLE && req_i) || state==BUSY.
- IDLE:
  - req_i=0: stay in IDLE.
  - req_i=1: latch we_i, addr_i, wdata_i.
  - Bad access (addr_i[1:0]!=0, or addr_i >= 4*2**ADDR_W): go to DONE with err_o=1 next cycle. No array access.
  - Otherwise: go to BUSY with cnt=LATENCY-1.
- BUSY:
  - cnt!=0: decrement cnt.
  - cnt==0: perform the access at this edge and go to DONE.
    - Store: array[addr[ADDR_W+1:2]] <= wdata; rdata_o unchanged.
    - Load: rdata_o <= array[index].
- DONE:
  - done_o=1 (err_o=1 if rejected), stall_o=0.
  - Unconditionally return to IDLE next edge.
  - done_o and err_o clear to 0 on that edge.
- Latency:
  - Request seen at cycle 0 gives done_o at cycle LATENCY+1.
  - Error path: done_o at cycle 1.
  - stall_o is high for cycles 0..LATENCY.
- rdata_o holds its last load value until the next successful load. It is not cleared by stores or errors.
- req_i and inputs changing or dropping during BUSY are ignored; the latched operation completes.
- req_i high in DONE is not accepted. It is re-sampled in IDLE on the following cycle (back-to-back accesses take LATENCY+2 cycles each).
- Reset mid-BUSY: the access is aborted, no array write occurs, and all outputs return to reset values immediately.
- Unused address bits above the range check have no effect beyond it.

Optional Feature:
Macro: DATA_MEM_BYTE_STROBE_EN
- Defined:
  - Adds input be_i[3:0], latched with req_i.
  - Stores write only the bytes whose be_i bit is 1 (bit n controls wdata[8n+7:8n]).
  - be_i=0000 completes normally with no array change.
  - Loads ignore be_i and always return the full word.
- Undefined: no be_i port; every store writes all 32 bits.

Test Plan:
- Reset: assert rst_i=0 mid-BUSY, release -> rdata_o=0, stall_o=0, done_o=0. A load from that address afterwards returns the prior contents, i.e. no partial write.
- Store then load, LATENCY=2:
  - Store 0xDEADBEEF to 0x10 with req at cycle 0 -> stall_o high cycles 0-2, done_o high cycle 3.
  - Load from 0x10 -> rdata_o=0xDEADBEEF at that load's done cycle.
- Misaligned: load from 0x13 -> done_o=1 and err_o=1 at cycle 1; rdata_o unchanged; array unchanged.
- Out of range, ADDR_W=8: store to 0x400 -> err_o pulse; a load from 0x0 afterwards shows the old value.
- Input churn: drop req_i and change addr_i to 0x20 during BUSY -> original address 0x10 is accessed; done_o still at cycle LATENCY+1. Back-to-back req_i held high -> done_o pulses every LATENCY+2 cycles.
- DATA_MEM_BYTE_STROBE_EN defined: word at 0x8 holds 0x11223344; store 0xAABBCCDD with be_i=0101 -> a load from 0x8 returns 0x11BB33DD.
